// File: rtl/vga_pingpong_ctrl.sv
// Pixel-feed controller: fetches frame pixels into two ping/pong line banks over a
// single-outstanding read port and serves one pixel per cycle to the VGA timing generator.
module vga_pingpong_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_STEP = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en_i,
  input  logic [31:0] base_addr_i,
  input  logic [19:0] frame_pixels_i,
  input  logic        vsync_i,
  input  logic        data_req_i,
  output logic [11:0] data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [11:0] mem_rdata_i,
  output logic        underrun_o,
  output logic        busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          vsync_q;
  logic          restart_pend_q, restart_pend_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic          fill_bank_q, fill_bank_d;
  logic          drain_bank_q, drain_bank_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [20:0]   pix_cnt_q, pix_cnt_d;
  logic [20:0]   pix_target;
  logic [11:0]   data_q, data_d;
  logic          underrun_q, underrun_d;
  logic [11:0]   bank_mem [2][DEPTH];

  logic restart, wr_en, disable_clr, rd_en, wr_wrap, rd_wrap;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      vsync_q        <= 1'b0;
      restart_pend_q <= 1'b0;
      bank_full_q    <= '0;
      fill_bank_q    <= 1'b0;
      drain_bank_q   <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fetch_addr_q   <= '0;
      pix_cnt_q      <= '0;
      data_q         <= '0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      vsync_q        <= vsync_i;
      restart_pend_q <= restart_pend_d;
      bank_full_q    <= bank_full_d;
      fill_bank_q    <= fill_bank_d;
      drain_bank_q   <= drain_bank_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fetch_addr_q   <= fetch_addr_d;
      pix_cnt_q      <= pix_cnt_d;
      data_q         <= data_d;
      underrun_q     <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) bank_mem[fill_bank_q][wr_ptr_q] <= mem_rdata_i;
  end

  // Next-state: a granted transaction always completes before restart or disable.
  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    wr_en       = 1'b0;
    disable_clr = 1'b0;
    pix_target  = ({1'b0, frame_pixels_i} + 21'(DEPTH - 1)) & ~21'(DEPTH - 1);
    unique case (state_q)
      S_IDLE: if (en_i && restart_pend_q) restart = 1'b1;
      S_FILL: begin
        if (mem_req_o && mem_gnt_i) begin
          state_d = S_WAIT;
        end else if (!en_i) begin
          if (!mem_req_o) begin
            state_d     = S_IDLE;
            disable_clr = 1'b1;
          end
        end else if (restart_pend_q) begin
          restart = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (!en_i) begin
            state_d     = S_IDLE;
            disable_clr = 1'b1;
          end else if (restart_pend_q) begin
            restart = 1'b1;
          end else begin
            wr_en   = 1'b1;
            state_d = (pix_cnt_q + 21'd1 == pix_target) ? S_DONE : S_FILL;
          end
        end
      end
      S_DONE: begin
        if (!en_i) begin
          state_d     = S_IDLE;
          disable_clr = 1'b1;
        end else if (restart_pend_q) begin
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (restart) state_d = S_FILL;
  end

  // Bank bookkeeping and drain path; restart overrides both fill and drain.
  always_comb begin
    restart_pend_d = (vsync_q & ~vsync_i & en_i) | (restart_pend_q & ~restart);
    bank_full_d    = bank_full_q;
    fill_bank_d    = fill_bank_q;
    drain_bank_d   = drain_bank_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fetch_addr_d   = fetch_addr_q;
    pix_cnt_d      = pix_cnt_q;

    wr_wrap    = wr_en && (wr_ptr_q == PW'(DEPTH - 1));
    rd_en      = en_i && data_req_i && bank_full_q[drain_bank_q] && !restart;
    rd_wrap    = rd_en && (rd_ptr_q == PW'(DEPTH - 1));
    data_d     = rd_en ? bank_mem[drain_bank_q][rd_ptr_q] : '0;
    underrun_d = en_i && data_req_i && !bank_full_q[drain_bank_q] && !restart;

    if (wr_en) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      fetch_addr_d = fetch_addr_q + 32'(ADDR_STEP);
      pix_cnt_d    = pix_cnt_q + 21'd1;
    end
    if (wr_wrap) begin
      bank_full_d[fill_bank_q] = 1'b1;
      fill_bank_d              = ~fill_bank_q;
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    if (rd_wrap) begin
      bank_full_d[drain_bank_q] = 1'b0;
      drain_bank_d              = ~drain_bank_q;
    end

    if (restart) begin
      bank_full_d  = '0;
      fill_bank_d  = 1'b0;
      drain_bank_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fetch_addr_d = base_addr_i;
      pix_cnt_d    = '0;
    end else if (disable_clr) begin
      bank_full_d = '0;
    end
  end

  always_comb begin
    mem_req_o  = (state_q == S_FILL) && !bank_full_q[fill_bank_q];
    mem_addr_o = mem_req_o ? fetch_addr_q : '0;
    busy_o     = (state_q == S_FILL) || (state_q == S_WAIT);
    data_o     = data_q;
    underrun_o = underrun_q;
  end

endmodule

// File: tb/tb_vga_pingpong_ctrl.sv
// Directed bench for vga_pingpong_ctrl: a memory responder checks request addresses
// against a queue, and drained pixels are compared against a scoreboard queue.
module tb_vga_pingpong_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        resetn, en_i, vsync_i, data_req_i;
  logic [31:0] base_addr_i;
  logic [19:0] frame_pixels_i;
  logic [11:0] data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [11:0] mem_rdata_i;
  logic        underrun_o, busy_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_addr[$];
  logic [11:0] dq[$];
  int unsigned rv_lat   = 1;
  int unsigned n_acc    = 0;
  logic [11:0] data_ofs = '0;
  bit          gnt_en   = 1'b1;
  bit          inject_rv = 1'b0;

  vga_pingpong_ctrl #(.DEPTH(16), .ADDR_STEP(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .en_i           (en_i),
    .base_addr_i    (base_addr_i),
    .frame_pixels_i (frame_pixels_i),
    .vsync_i        (vsync_i),
    .data_req_i     (data_req_i),
    .data_o         (data_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .underrun_o     (underrun_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Memory model: grant while gnt_en, return pixel index + data_ofs after rv_lat cycles.
  initial begin : responder
    int unsigned cnt;
    logic [11:0] pend;
    bit          have;
    cnt = 0;
    pend = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_rvalid_i = 1'b0;
      if (inject_rv) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 12'hABC;
        inject_rv    = 1'b0;
      end
      if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = pend;
        end
      end
      mem_gnt_i = mem_req_o & gnt_en;
      if (mem_req_o && mem_gnt_i) begin
        have = (exp_addr.size() != 0);
        chk("req_expected", 32'(have), 32'd1);
        if (have) chk("req_addr", mem_addr_o, exp_addr.pop_front());
        pend = 12'((mem_addr_o - BASE) >> 1) + data_ofs;
        cnt  = rv_lat;
        n_acc++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_addrs(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_addr.push_back(BASE + 32'(2 * i));
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vsync_i = 1'b0;
    @(negedge clk);
    vsync_i = 1'b1;
  endtask

  task automatic wait_addr_drain(input string tag, input int unsigned budget);
    int unsigned c;
    c = 0;
    while (exp_addr.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(exp_addr.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic drain_chk(input string tag, input logic [11:0] first, input int unsigned n);
    logic [11:0] e;
    for (int unsigned i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = dq.pop_front();
        chk({tag, "_pix"}, 32'(data_o), 32'(e));
        chk({tag, "_unr"}, 32'(underrun_o), 32'd0);
      end
      if (i < n) begin
        data_req_i = 1'b1;
        dq.push_back(first + 12'(i));
      end else begin
        data_req_i = 1'b0;
      end
    end
  endtask

  initial begin : stim
    logic [11:0] e;
    resetn = 1'b0;
    en_i = 1'b0;
    vsync_i = 1'b1;
    data_req_i = 1'b0;
    base_addr_i = BASE;
    frame_pixels_i = 20'd307200;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_unr", 32'(underrun_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    resetn = 1'b1;
    en_i = 1'b1;
    @(negedge clk);

    // Fill both banks from 0x1000 onward, then stall.
    push_addrs(32);
    vsync_pulse();
    wait_addr_drain("t1_requests", 200);
    chk("t1_stall_req", 32'(mem_req_o), 32'd0);
    chk("t1_busy", 32'(busy_o), 32'd1);
    chk("t1_no_unr", 32'(underrun_o), 32'd0);

    // Drain 32 pixels; fill resumes at 0x1040 once bank 0 frees.
    for (int unsigned i = 32; i < 64; i++) exp_addr.push_back(BASE + 32'(2 * i));
    drain_chk("t2", 12'h000, 32);
    wait_addr_drain("t2_refill", 200);
    chk("t2_stall_req", 32'(mem_req_o), 32'd0);

    // Requests right after restart underrun until bank 0 fills.
    data_ofs = 12'h500;
    push_addrs(32);
    vsync_pulse();
    @(negedge clk);
    data_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_unr", 32'(underrun_o), 32'd1);
      chk("t3_data_zero", 32'(data_o), 32'd0);
    end
    data_req_i = 1'b0;
    repeat (50) @(negedge clk);
    drain_chk("t3", 12'h500, 3);
    wait_addr_drain("t3_requests", 200);

    // Vsync during WAIT: late data dropped, refetch from base into slot 0.
    data_ofs = 12'h600;
    rv_lat = 5;
    exp_addr.push_back(BASE);
    push_addrs(32);
    vsync_pulse();
    @(negedge clk);
    chk("t4_req", 32'(mem_req_o), 32'd1);
    chk("t4_addr", mem_addr_o, BASE);
    @(negedge clk);
    vsync_i = 1'b0;
    @(negedge clk);
    vsync_i = 1'b1;
    data_ofs = 12'h700;
    rv_lat = 1;
    @(negedge clk);
    chk("t4_wait_no_req", 32'(mem_req_o), 32'd0);
    chk("t4_wait_busy", 32'(busy_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_rereq", 32'(mem_req_o), 32'd1);
    chk("t4_readdr", mem_addr_o, BASE);
    wait_addr_drain("t4_requests", 300);
    drain_chk("t4", 12'h700, 4);

    // 40-pixel frame rounds up to 48 fetches; restart beats a drain in the same cycle.
    frame_pixels_i = 20'd40;
    data_ofs = 12'h100;
    n_acc = 0;
    push_addrs(48);
    dq.delete();
    for (int i = 0; i < 48; i++) dq.push_back(12'h100 + 12'(i));
    @(negedge clk);
    vsync_i = 1'b0;
    @(negedge clk);
    vsync_i = 1'b1;
    data_req_i = 1'b1;
    @(negedge clk);
    chk("t5_restart_data", 32'(data_o), 32'd0);
    chk("t5_restart_unr", 32'(underrun_o), 32'd0);
    for (int c = 0; c < 600 && dq.size() > 0; c++) begin
      @(negedge clk);
      if (underrun_o) begin
        chk("t5_unr_data", 32'(data_o), 32'd0);
      end else begin
        e = dq.pop_front();
        chk("t5_pix", 32'(data_o), 32'(e));
      end
    end
    chk("t5_all_pixels", 32'(dq.size()), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_req_count", 32'(n_acc), 32'd48);
    chk("t5_busy_done", 32'(busy_o), 32'd0);
    chk("t5_req_done", 32'(mem_req_o), 32'd0);
    chk("t5_addr_q", 32'(exp_addr.size()), 32'd0);
    chk("t5_unr_after", 32'(underrun_o), 32'd1);
    chk("t5_data_after", 32'(data_o), 32'd0);

    // Disabled: drain outputs zero and underrun is suppressed.
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("en_off_unr", 32'(underrun_o), 32'd0);
    chk("en_off_data", 32'(data_o), 32'd0);
    chk("en_off_busy", 32'(busy_o), 32'd0);
    data_req_i = 1'b0;
    en_i = 1'b1;

    // Asynchronous reset with a request pending; stray rvalid afterwards is ignored.
    frame_pixels_i = 20'd307200;
    gnt_en = 1'b0;
    vsync_pulse();
    for (int c = 0; c < 10 && !mem_req_o; c++) @(negedge clk);
    chk("t6_req_pre", 32'(mem_req_o), 32'd1);
    chk("t6_busy_pre", 32'(busy_o), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_req", 32'(mem_req_o), 32'd0);
    chk("t6_async_busy", 32'(busy_o), 32'd0);
    chk("t6_async_data", 32'(data_o), 32'd0);
    chk("t6_async_addr", mem_addr_o, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    gnt_en = 1'b1;
    inject_rv = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_post_busy", 32'(busy_o), 32'd0);
    chk("t6_post_req", 32'(mem_req_o), 32'd0);
    data_ofs = 12'h200;
    push_addrs(32);
    vsync_pulse();
    wait_addr_drain("t6_requests", 200);
    drain_chk("t6", 12'h200, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_pingpong_ctrl.md
Name: vga_pingpong_ctrl

Overview:
- Pixel-feed controller for the VGA timing generator.
- Fetches frame pixels from memory over a single-outstanding read port into two line banks (ping/pong), and serves one pixel per cycle on the timing generator's data request.
- Schedules the bank fill against the display drain, restarts at every vertical sync, and flags underruns.

Parameters:
- DEPTH, 16, pixels per bank (power of two, >=2)
- ADDR_STEP, 2, byte address increment per pixel (one 12-bit pixel per halfword)

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- en_i  in  1  fetch/serve enable
- base_addr_i  in  32  frame buffer byte base address
- frame_pixels_i  in  20  pixels per frame (e.g. 307200)
- vsync_i  in  1  vertical sync from timing generator, low during pulse
- data_req_i  in  1  pixel request from timing generator
- data_o  out  12  pixel {B[11:8],G[7:4],R[3:0]}
- mem_req_o  out  1  read request
- mem_addr_o  out  32  read byte address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  12  read data
- underrun_o  out  1  one-cycle pulse: request while drain bank not full
- busy_o  out  1  fill FSM not in IDLE/DONE

Behaviour:
- Reset: all outputs 0. Internal state also resets: bank_full=2'b00, fill_bank=0, drain_bank=0, pointers=0, FSM=IDLE.
- Frame start: vsync_i falling edge (1->0, registered detect) with en_i=1 sets restart_pend.
- Restart is taken only from IDLE, FILL before grant, or DONE. A granted transaction in WAIT completes first and its data is dropped.
- On restart: bank_full=0, both banks/pointers=0, fetch_addr=base_addr_i, pix_cnt=0, restart_pend=0, state FILL.
- Fill FSM states:
  - IDLE: wait for restart.
  - FILL: mem_req_o=1, mem_addr_o=fetch_addr, held stable until mem_gnt_i. On grant -> WAIT. If bank_full[fill_bank]=1, hold mem_req_o=0 in FILL (no request issued).
  - WAIT: on mem_rvalid_i:
    - If restart_pend: drop data, then restart.
    - Otherwise: write mem_rdata_i to bank[fill_bank][wr_ptr], wr_ptr++, fetch_addr+=ADDR_STEP, pix_cnt++.
    - When wr_ptr wraps (DEPTH writes): set bank_full[fill_bank], toggle fill_bank.
    - Then -> DONE if pix_cnt==frame_pixels_i rounded up to a multiple of DEPTH, else -> FILL.
  - DONE: no requests until next restart.
- frame_pixels_i not a multiple of DEPTH: fetch continues to the next multiple; the extra pixels are fetched and drained normally.
- Drain, 1-cycle latency:
  - data_req_i=1 and bank_full[drain_bank]=1: data_o <= bank[drain_bank][rd_ptr], rd_ptr++. On wrap, clear bank_full[drain_bank] and toggle drain_bank.
  - data_req_i=1 and bank not full: data_o <= 12'h000, underrun_o=1 next cycle, rd_ptr unchanged.
  - data_req_i=0: data_o <= 12'h000.
- Simultaneous set (fill) and clear (drain) in one cycle always target different banks; both take effect.
- Restart in the same cycle as a drain: restart wins; data_o <= 0.
- en_i=0:
  - Fill FSM finishes any granted transaction (data dropped), then -> IDLE with bank_full cleared.
  - Drain outputs 0; underrun_o is suppressed.
  - An ungranted request is held until grant, then handled as WAIT drop.
- busy_o=1 in FILL/WAIT.
- Async reset mid-transaction: immediate return to reset state. Any late mem_rvalid_i after reset release is ignored (FSM not in WAIT).

Test Plan:
1. Reset, then en_i=1, vsync falling, base=0x1000, gnt same cycle, rvalid 1 cycle later -> addresses 0x1000,0x1002,…,0x103E (32 requests), then mem_req_o=0 with both banks full.
2. Memory data = index, then data_req_i held 32 cycles -> data_o = 0..31 on cycles 1..32 after first req, no underrun; fill resumes after bank 0 drains.
3. data_req_i asserted immediately after restart, before any rvalid -> data_o=0, underrun_o pulse per request cycle, rd_ptr unchanged; first pixel still delivered once bank 0 fills.
4. Vsync falling while in WAIT with rvalid delayed 5 cycles -> returned data dropped, next mem_addr_o=base, bank_full=0.
5. frame_pixels_i=40, DEPTH=16, continuous drain -> exactly 48 requests, then DONE, busy_o=0.
6. resetn low during FILL with mem_req_o=1 -> mem_req_o, data_o, busy_o go 0 asynchronously; a stray rvalid after release causes no write.
